// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns pcF, issues one instruction-memory request at a time,
// holds the fetched word for Decode and applies jump/branch/exception redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] EXC_PC   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flush_excM,
  input  logic        jumpD,
  input  logic        branch_takeD,
  input  logic [31:0] pc_jumpD,
  input  logic [31:0] pc_branchD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        instr_validF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic        pend_valid;
  logic        pend_exc;
  logic [31:0] pend_pc;

  logic        exc_now;
  logic        jb_now;
  logic [31:0] jb_target;
  logic [31:0] next_pc;

  always_comb begin
    exc_now   = pend_exc | flush_excM;
    jb_now    = jumpD | branch_takeD;
    jb_target = jumpD ? pc_jumpD : pc_branchD;
    // A redirect arriving in the consume cycle bypasses the pending register.
    if (jb_now)
      next_pc = jb_target;
    else if (pend_valid)
      next_pc = pend_pc;
    else
      next_pc = pcF + 32'd4;
  end

  assign inst_addr = pcF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      inst_req     <= 1'b1;
      pcF          <= RESET_PC;
      instrF       <= '0;
      instr_validF <= 1'b0;
      pend_valid   <= 1'b0;
      pend_exc     <= 1'b0;
      pend_pc      <= '0;
    end else begin
      // Capture first; the state cases below clear pending when it is applied.
      if (flush_excM) begin
        pend_valid <= 1'b1;
        pend_exc   <= 1'b1;
        pend_pc    <= EXC_PC;
      end else if (jb_now && !pend_exc) begin
        pend_valid <= 1'b1;
        pend_pc    <= jb_target;
      end

      case (state)
        S_REQ: begin
          if (inst_addr_ok) begin
            state    <= S_WAIT;
            inst_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (exc_now) begin
              pcF        <= EXC_PC;
              pend_valid <= 1'b0;
              pend_exc   <= 1'b0;
              state      <= S_REQ;
              inst_req   <= 1'b1;
            end else begin
              instrF       <= inst_rdata;
              instr_validF <= 1'b1;
              state        <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (exc_now) begin
            instr_validF <= 1'b0;
            pcF          <= EXC_PC;
            pend_valid   <= 1'b0;
            pend_exc     <= 1'b0;
            state        <= S_REQ;
            inst_req     <= 1'b1;
          end else if (!stallD) begin
            instr_validF <= 1'b0;
            pcF          <= next_pc;
            pend_valid   <= 1'b0;
            state        <= S_REQ;
            inst_req     <= 1'b1;
          end
        end
        default: begin
          state        <= S_REQ;
          inst_req     <= 1'b1;
          instr_validF <= 1'b0;
        end
      endcase
    end
  end

endmodule
